decode_regfile: RTL and testbench
=================================

// Module: decode_regfile
// PURPOSE
//  Instruction-decode stage of the single-cycle MIPS datapath; sits directly downstream of the
//  instruction memory. Splits the 32-bit instruction into fields, drives control signals, and
//  reads/writes the 32x32 general register file. Sign/zero-extends immediates. Keeps a sticky
//  illegal-opcode flag and a count of decoded instructions.
// PARAMETERS
//  BYPASS      1   1: same-cycle write data is forwarded to rs_data/rt_data; 0: old value is read
//  CNT_W       32  width of instr_count
// PORTS
//  clock         in   1   single clock; all state updates on its rising edge
//  reset         in   1   synchronous, active-high reset
//  instruction   in   32  word from instruction memory
//  instr_valid   in   1   instruction is valid this cycle (gates counter and sticky flag)
//  wb_en         in   1   write-back enable from the write-back mux
//  wb_addr       in   5   write-back destination register
//  wb_data       in   32  write-back data
//  rs_data       out  32  register[instruction[25:21]]
//  rt_data       out  32  register[instruction[20:16]]
//  ext_imm       out  32  extended immediate (see below)
//  shamt         out  5   instruction[10:6]
//  dst_sel       out  2   0=rt, 1=rd, 2=$31 (jal)
//  alu_src       out  1   1 = ext_imm feeds ALU B
//  alu_op        out  4   mips_pkg ALU encoding
//  mem_read      out  1   lw
//  mem_write     out  1   sw
//  mem_to_reg    out  2   0=ALU, 1=memory, 2=PC+4 (jal)
//  reg_write     out  1   instruction writes a register
//  branch_eq     out  1   beq
//  branch_ne     out  1   bne
//  jump          out  1   j/jal
//  jump_reg      out  1   jr
//  illegal       out  1   current instruction is not decodable (combinational)
//  illegal_seen  out  1   sticky: an illegal instruction was decoded while instr_valid was high
//  instr_count   out  CNT_W  number of cycles with instr_valid high since reset
// BEHAVIOUR
//  - Reset (clock edge with reset=1): all 32 registers <= 0, illegal_seen <= 0, instr_count <= 0.
//    Reset overrides a simultaneous write. Reset mid-program clears all architectural state.
//  - Register write: at the clock edge, if wb_en && wb_addr!=0 then reg[wb_addr] <= wb_data.
//    A write to $0 is discarded; $0 always reads 0.
//  - Reads are combinational (zero latency). If BYPASS=1 and wb_en && wb_addr==rs && rs!=0, then
//    rs_data = wb_data (same for rt). If BYPASS=0, the pre-edge value is read.
//  - Supported instructions: R-type funct add/sub/and/or/slt/sll/srl/jr; I-type addi/andi/ori/
//    slti/lw/sw/beq/bne/lui; J-type j/jal. Any other opcode/funct: illegal=1, and all side-effect
//    controls (reg_write, mem_read, mem_write, branch_*, jump*) are forced to 0.
//  - ext_imm: zero-extended for andi/ori; {imm,16'b0} for lui; sign-extended otherwise.
//  - jal: reg_write=1, dst_sel=2, mem_to_reg=2. jr: reg_write=0, jump_reg=1.
//  - The 32'h00000000 word (sll $0,$0,0 / nop) is legal and has no effect.
//  - Counter: instr_count increments by 1 on each edge with instr_valid=1 and reset=0; it wraps
//    modulo 2^CNT_W. illegal_seen <= 1 when instr_valid && illegal; it is cleared only by reset.
//  - All control outputs are purely combinational from instruction; they do not depend on
//    instr_valid.
// STRUCTURE
//  - mips_pkg: opcode/funct localparams, ALU-op encodings, dst_sel/mem_to_reg codes.
//  - Sub-module reg_file (32x32, two async read ports, one sync write port, $0 hardwired,
//    BYPASS parameter). The decoder and extender stay in decode_regfile.
// TESTING
//  1. Reset: hold reset 2 cycles -> rs_data=rt_data=0 for all addresses, instr_count=0, illegal_seen=0.
//  2. Write $8=32'hDEADBEEF, then instruction add $t0,$t0,$t0 -> rs_data=rt_data=32'hDEADBEEF; write $0=5 -> $0 reads 0.
//  3. BYPASS=1: wb_en=1, wb_addr=9, wb_data=7, rs=9 in same cycle -> rs_data=7; BYPASS=0 -> old value.
//  4. Decode: addi imm=16'hFFFF -> ext_imm=32'hFFFFFFFF, alu_src=1; ori -> 32'h0000FFFF; lui 16'h1234 -> 32'h12340000; jal -> dst_sel=2, mem_to_reg=2, jump=1.
//  5. Opcode 6'h3F with instr_valid=1 -> illegal=1, reg_write=mem_write=0; illegal_seen=1 next cycle and stays 1 until reset.
//  6. Count: 5 valid cycles, 2 invalid -> instr_count=5; reset asserted while wb_en=1 -> target register 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcode/funct values, ALU-op encoding,
// destination and write-back source selectors, and the decoded control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } dst_sel_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_PC4 = 2'd2
    } mem_to_reg_e;

    typedef struct packed {
        dst_sel_e    dst_sel;
        logic        alu_src;
        alu_op_e     alu_op;
        logic        mem_read;
        logic        mem_write;
        mem_to_reg_e mem_to_reg;
        logic        reg_write;
        logic        branch_eq;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        logic        illegal;
    } ctrl_t;

    // Logical immediates are zero-extended, lui places imm in the upper half.
    function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        if (op == OP_ANDI || op == OP_ORI)
            return {16'h0000, imm};
        else if (op == OP_LUI)
            return {imm, 16'h0000};
        else
            return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// $0 hardwired to zero, optional same-cycle write-to-read forwarding.
module reg_file
    import mips_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data
);

    logic [31:0] r_regs [0:31];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++)
                r_regs[i] <= '0;
        end else if (i_wb_en && i_wb_addr != 5'd0) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        o_rs_data = (i_rs_addr == 5'd0) ? '0 : r_regs[i_rs_addr];
        o_rt_data = (i_rt_addr == 5'd0) ? '0 : r_regs[i_rt_addr];
        if (BYPASS != 0) begin
            if (i_wb_en && i_wb_addr == i_rs_addr && i_rs_addr != 5'd0)
                o_rs_data = i_wb_data;
            if (i_wb_en && i_wb_addr == i_rt_addr && i_rt_addr != 5'd0)
                o_rt_data = i_wb_data;
        end
    end

endmodule

// File: rtl/decode_regfile.sv
// MIPS instruction-decode stage: field split, control decode, immediate extension,
// register file access, sticky illegal flag and valid-instruction counter.
module decode_regfile
    import mips_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             instr_valid,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic [31:0]      ext_imm,
    output logic [4:0]       shamt,
    output logic [1:0]       dst_sel,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             jump,
    output logic             jump_reg,
    output logic             illegal,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] instr_count
);

    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    ctrl_t            w_ctrl;
    logic             r_illegal_seen;
    logic [CNT_W-1:0] r_instr_count;

    assign w_opcode = instruction[31:26];
    assign w_funct  = instruction[5:0];

    reg_file #(
        .BYPASS(BYPASS)
    ) u_reg_file (
        .clock     (clock),
        .reset     (reset),
        .i_rs_addr (instruction[25:21]),
        .i_rt_addr (instruction[20:16]),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .o_rs_data (rs_data),
        .o_rt_data (rt_data)
    );

    always_comb begin
        w_ctrl = '0;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.dst_sel   = DST_RD;
                w_ctrl.reg_write = 1'b1;
                case (w_funct)
                    FN_ADD:  w_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  w_ctrl.alu_op = ALU_SUB;
                    FN_AND:  w_ctrl.alu_op = ALU_AND;
                    FN_OR:   w_ctrl.alu_op = ALU_OR;
                    FN_SLT:  w_ctrl.alu_op = ALU_SLT;
                    FN_SLL:  w_ctrl.alu_op = ALU_SLL;
                    FN_SRL:  w_ctrl.alu_op = ALU_SRL;
                    FN_JR: begin
                        w_ctrl.reg_write = 1'b0;
                        w_ctrl.jump_reg  = 1'b1;
                    end
                    default: w_ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; end
            OP_SLTI: begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_SLT; end
            OP_ANDI: begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_AND; end
            OP_ORI:  begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_OR;  end
            OP_LUI:  begin w_ctrl.alu_src = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_LUI; end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = M2R_MEM;
                w_ctrl.reg_write  = 1'b1;
            end
            OP_SW:   begin w_ctrl.alu_src = 1'b1; w_ctrl.mem_write = 1'b1; end
            OP_BEQ:  begin w_ctrl.alu_op = ALU_SUB; w_ctrl.branch_eq = 1'b1; end
            OP_BNE:  begin w_ctrl.alu_op = ALU_SUB; w_ctrl.branch_ne = 1'b1; end
            OP_J:    w_ctrl.jump = 1'b1;
            OP_JAL: begin
                w_ctrl.jump       = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.dst_sel    = DST_RA;
                w_ctrl.mem_to_reg = M2R_PC4;
            end
            default: w_ctrl.illegal = 1'b1;
        endcase
        // Undecodable words must not leave any partial R-type controls behind.
        if (w_ctrl.illegal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
        end
    end

    assign ext_imm    = extend_imm(w_opcode, instruction[15:0]);
    assign shamt      = instruction[10:6];
    assign dst_sel    = w_ctrl.dst_sel;
    assign alu_src    = w_ctrl.alu_src;
    assign alu_op     = w_ctrl.alu_op;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write;
    assign branch_eq  = w_ctrl.branch_eq;
    assign branch_ne  = w_ctrl.branch_ne;
    assign jump       = w_ctrl.jump;
    assign jump_reg   = w_ctrl.jump_reg;
    assign illegal    = w_ctrl.illegal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal_seen <= 1'b0;
            r_instr_count  <= '0;
        end else if (instr_valid) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
            if (w_ctrl.illegal)
                r_illegal_seen <= 1'b1;
        end
    end

    assign illegal_seen = r_illegal_seen;
    assign instr_count  = r_instr_count;

endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboard bench for decode_regfile: a bypassing 32-bit-counter instance and a
// non-bypassing 3-bit-counter instance share stimulus and are checked against a mnemonic-level model.
module tb_decode_regfile;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic [31:0] rs_data, rt_data, ext_imm;
    logic [4:0]  shamt;
    logic [1:0]  dst_sel, mem_to_reg;
    logic        alu_src, mem_read, mem_write, reg_write;
    logic [3:0]  alu_op;
    logic        branch_eq, branch_ne, jump, jump_reg, illegal, illegal_seen;
    logic [31:0] instr_count;

    logic [31:0] nb_rs, nb_rt, nb_ext;
    logic [4:0]  nb_shamt;
    logic [1:0]  nb_dst, nb_m2r;
    logic        nb_alu_src, nb_mr, nb_mw, nb_rw;
    logic [3:0]  nb_alu_op;
    logic        nb_beq, nb_bne, nb_j, nb_jr, nb_ill, nb_seen;
    logic [2:0]  nb_cnt;

    always #5 clock = ~clock;

    decode_regfile #(.BYPASS(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_data(rs_data), .rt_data(rt_data), .ext_imm(ext_imm), .shamt(shamt),
        .dst_sel(dst_sel), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg),
        .illegal(illegal), .illegal_seen(illegal_seen), .instr_count(instr_count)
    );

    decode_regfile #(.BYPASS(0), .CNT_W(3)) dut_nb (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_data(nb_rs), .rt_data(nb_rt), .ext_imm(nb_ext), .shamt(nb_shamt),
        .dst_sel(nb_dst), .alu_src(nb_alu_src), .alu_op(nb_alu_op), .mem_read(nb_mr),
        .mem_write(nb_mw), .mem_to_reg(nb_m2r), .reg_write(nb_rw),
        .branch_eq(nb_beq), .branch_ne(nb_bne), .jump(nb_j), .jump_reg(nb_jr),
        .illegal(nb_ill), .illegal_seen(nb_seen), .instr_count(nb_cnt)
    );

    typedef enum int {
        M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_JR,
        M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_BAD
    } mn_e;

    typedef struct {
        logic [31:0] rs, rt, rs_nb, rt_nb, ext, cnt;
        logic [4:0]  shamt;
        logic [1:0]  dst, m2r;
        logic [3:0]  alu_op;
        logic        alu_src, mr, mw, rw, beq, bne, j, jr, ill, seen;
        logic [2:0]  cnt_nb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [0:31];
    logic        m_seen;
    logic [31:0] m_cnt;
    int          checks   = 0;
    int          failures = 0;

    function automatic mn_e classify(input logic [31:0] ins);
        mn_e m;
        m = M_BAD;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: m = M_ADD;  6'h22: m = M_SUB;  6'h24: m = M_AND;  6'h25: m = M_OR;
                6'h2A: m = M_SLT;  6'h00: m = M_SLL;  6'h02: m = M_SRL;  6'h08: m = M_JR;
                default: m = M_BAD;
            endcase
            6'h08: m = M_ADDI; 6'h0A: m = M_SLTI; 6'h0C: m = M_ANDI; 6'h0D: m = M_ORI;
            6'h0F: m = M_LUI;  6'h23: m = M_LW;   6'h2B: m = M_SW;   6'h04: m = M_BEQ;
            6'h05: m = M_BNE;  6'h02: m = M_J;    6'h03: m = M_JAL;
            default: m = M_BAD;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a, input logic byp,
                                             input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (byp && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic exp_t expect_now(input logic [31:0] ins, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
        exp_t  e;
        mn_e   m;
        logic [15:0] imm;
        m   = classify(ins);
        imm = ins[15:0];
        e.rs     = rd_model(ins[25:21], 1'b1, we, wa, wd);
        e.rt     = rd_model(ins[20:16], 1'b1, we, wa, wd);
        e.rs_nb  = rd_model(ins[25:21], 1'b0, we, wa, wd);
        e.rt_nb  = rd_model(ins[20:16], 1'b0, we, wa, wd);
        e.shamt  = ins[10:6];
        if (m inside {M_ANDI, M_ORI})  e.ext = {16'h0, imm};
        else if (m == M_LUI)           e.ext = {imm, 16'h0};
        else                           e.ext = {{16{imm[15]}}, imm};
        e.ill     = (m == M_BAD);
        e.rw      = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL,
                              M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LUI, M_LW, M_JAL};
        e.alu_src = m inside {M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LUI, M_LW, M_SW};
        e.mr      = (m == M_LW);
        e.mw      = (m == M_SW);
        e.beq     = (m == M_BEQ);
        e.bne     = (m == M_BNE);
        e.j       = m inside {M_J, M_JAL};
        e.jr      = (m == M_JR);
        e.dst     = (m == M_JAL) ? 2'd2 :
                    (m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_JR}) ? 2'd1 : 2'd0;
        e.m2r     = (m == M_JAL) ? 2'd2 : (m == M_LW) ? 2'd1 : 2'd0;
        case (m)
            M_SUB, M_BEQ, M_BNE: e.alu_op = ALU_SUB;
            M_AND, M_ANDI:       e.alu_op = ALU_AND;
            M_OR, M_ORI:         e.alu_op = ALU_OR;
            M_SLT, M_SLTI:       e.alu_op = ALU_SLT;
            M_SLL:               e.alu_op = ALU_SLL;
            M_SRL:               e.alu_op = ALU_SRL;
            M_LUI:               e.alu_op = ALU_LUI;
            default:             e.alu_op = ALU_ADD;
        endcase
        e.seen   = m_seen;
        e.cnt    = m_cnt;
        e.cnt_nb = m_cnt[2:0];
        return e;
    endfunction

    task automatic drive(input logic rst, input logic [31:0] ins, input logic vld,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        reset = rst; instruction = ins; instr_valid = vld;
        wb_en = we; wb_addr = wa; wb_data = wd;
        sb.push_back(expect_now(ins, we, wa, wd));
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_seen = 1'b0;
            m_cnt  = 32'd0;
        end else begin
            if (we && wa != 5'd0) m_regs[wa] = wd;
            if (vld) begin
                m_cnt = m_cnt + 32'd1;
                if (classify(ins) == M_BAD) m_seen = 1'b1;
            end
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h instr=%h t=%0t", name, act, exp, instruction, $time);
        end
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rs_data",      rs_data,      e.rs);
            chk("rt_data",      rt_data,      e.rt);
            chk("nb_rs_data",   nb_rs,        e.rs_nb);
            chk("nb_rt_data",   nb_rt,        e.rt_nb);
            chk("ext_imm",      ext_imm,      e.ext);
            chk("shamt",        32'(shamt),   32'(e.shamt));
            chk("dst_sel",      32'(dst_sel), 32'(e.dst));
            chk("alu_src",      32'(alu_src), 32'(e.alu_src));
            chk("alu_op",       32'(alu_op),  32'(e.alu_op));
            chk("mem_read",     32'(mem_read),  32'(e.mr));
            chk("mem_write",    32'(mem_write), 32'(e.mw));
            chk("mem_to_reg",   32'(mem_to_reg), 32'(e.m2r));
            chk("reg_write",    32'(reg_write), 32'(e.rw));
            chk("branch_eq",    32'(branch_eq), 32'(e.beq));
            chk("branch_ne",    32'(branch_ne), 32'(e.bne));
            chk("jump",         32'(jump),      32'(e.j));
            chk("jump_reg",     32'(jump_reg),  32'(e.jr));
            chk("illegal",      32'(illegal),   32'(e.ill));
            chk("illegal_seen", 32'(illegal_seen), 32'(e.seen));
            chk("instr_count",  instr_count,    e.cnt);
            chk("nb_illegal_seen", 32'(nb_seen), 32'(e.seen));
            chk("nb_instr_count",  32'(nb_cnt),  32'(e.cnt_nb));
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  op_tab [0:10];
        logic [5:0]  fn_tab [0:7];
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 31));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        op_tab = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
        case ($urandom_range(0, 7))
            0:       return $urandom;
            1, 2, 3: return {6'h00, rs, rt, rd, sh, fn_tab[$urandom_range(0, 7)]};
            default: return {op_tab[$urandom_range(0, 10)], rs, rt, imm};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_seen = 1'b0;
        m_cnt  = 32'd0;
        reset = 1'b1; instruction = 32'd0; instr_valid = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        @(posedge clock);
        #1;
        drive(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++)
            drive(1'b0, {6'h00, 5'(i), 5'(31 - i), 16'h0020}, 1'b0, 1'b0, 5'd0, 32'd0);

        drive(1'b0, 32'd0, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
        drive(1'b0, {6'h00, 5'd8, 5'd8, 5'd8, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'd5);
        drive(1'b0, {6'h00, 5'd0, 5'd0, 5'd8, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(1'b0, {6'h00, 5'd9, 5'd8, 5'd10, 5'd0, 6'h20}, 1'b1, 1'b1, 5'd9, 32'd7);
        drive(1'b0, {6'h00, 5'd9, 5'd9, 5'd10, 5'd0, 6'h20}, 1'b1, 1'b0, 5'd0, 32'd0);

        drive(1'b0, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(1'b0, {6'h0D, 5'd1, 5'd2, 16'hFFFF}, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(1'b0, {6'h0F, 5'd0, 5'd2, 16'h1234}, 1'b1, 1'b0, 5'd0, 32'd0);
        drive(1'b0, {6'h03, 26'h0000100},          1'b1, 1'b0, 5'd0, 32'd0);
        drive(1'b0, {6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08}, 1'b1, 1'b0, 5'd0, 32'd0);

        drive(1'b0, {6'h3F, 26'h0}, 1'b1, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'd0, i[0], 1'b0, 5'd0, 32'd0);

        drive(1'b1, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 7; i++)
            drive(1'b0, 32'd0, (i != 2 && i != 5), 1'b0, 5'd0, 32'd0);
        drive(1'b0, {6'h00, 5'd3, 5'd0, 16'h0020}, 1'b0, 1'b1, 5'd3, 32'h55);
        drive(1'b1, {6'h00, 5'd3, 5'd0, 16'h0020}, 1'b0, 1'b1, 5'd3, 32'h99);
        drive(1'b0, {6'h00, 5'd3, 5'd3, 16'h0020}, 1'b0, 1'b0, 5'd0, 32'd0);

        for (int i = 0; i < 400; i++)
            drive(($urandom_range(0, 63) == 0), rand_instr(), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clock);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
